// File: rtl/nm_pkg.sv
// Shared types and helpers for the neuron integrator: FSM state encoding,
// default address width and a saturating adder.
package nm_pkg;

    typedef enum logic [1:0] {INIT, IDLE, SCAN, DRAIN} state_t;

    localparam int NEURON_NO_DEF = 256;
    localparam int ADDR_WID      = $clog2(NEURON_NO_DEF);

    function automatic int addr_wid(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Unsigned add clamped to 2**wid-1 instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned wid);
        logic [64:0] sum;
        logic [63:0] max_val;
        max_val = (64'd1 << wid) - 64'd1;
        sum     = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/neuron_integrator_vmem_ram.sv
// Membrane-potential storage: one write port, one synchronous read port,
// contents are not reset (the integrator clears them by sweeping).
module vmem_ram #(
    parameter int DEPTH = 256,
    parameter int WID   = 24,
    parameter int AW    = 8
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [WID-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [WID-1:0] rdata
);

    logic [WID-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/neuron_integrator.sv
// Per-time-step scanner of the amplitude RAM: leak-integrates each neuron's
// amplitude into its membrane potential and emits a spike two cycles after issue.
//
// state | meaning
// INIT  | clearing vmem, one address per cycle
// IDLE  | waiting for a time-step tick
// SCAN  | issuing one neuron per cycle to the amplitude block
// DRAIN | retiring the last two pipeline stages, done on the second cycle
module neuron_integrator
    import nm_pkg::*;
#(
    parameter int                  NEURON_NO  = NEURON_NO_DEF,
    parameter int                  AMPL_WID   = 20,
    parameter int                  VMEM_WID   = 24,
    parameter int unsigned         LEAK_SHIFT = 4,
    parameter logic [VMEM_WID-1:0] THRESH     = 24'h010000,
    localparam int                 AW         = addr_wid(NEURON_NO)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [AMPL_WID-1:0] ampl_in,
    output logic                scan_en,
    output logic [AW-1:0]       scan_addr,
    output logic                sp_out,
    output logic [AW-1:0]       sp_addr,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam logic [AW-1:0] LAST = AW'(NEURON_NO - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                drain_q, drain_d;
    logic                tick_ok;
    logic                overrun_q;

    logic                s1_valid;
    logic [AW-1:0]       s1_addr;
    logic [AMPL_WID-1:0] s1_ampl;
    logic                fwd_hit;
    logic [VMEM_WID-1:0] fwd_data;
    logic                s2_valid;
    logic                s2_fire;
    logic [AW-1:0]       s2_addr;
    logic [VMEM_WID-1:0] s2_vmem;

    logic                ram_we;
    logic [AW-1:0]       ram_waddr;
    logic [VMEM_WID-1:0] ram_wdata;
    logic [VMEM_WID-1:0] ram_rdata;
    logic [VMEM_WID-1:0] v_cur, v_leak, v_next;
    logic                fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            addr_q    <= '0;
            drain_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            overrun_q <= overrun_q | (tick & ~tick_ok);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = 1'b0;
        tick_ok = 1'b0;
        done    = 1'b0;
        case (state_q)
            INIT: begin
                if (addr_q == LAST) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    addr_d  = '0;
                    tick_ok = 1'b1;
                end
            end
            SCAN: begin
                if (addr_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    done    = 1'b1;
                    addr_d  = '0;
                    // A tick landing on done starts the next sweep with no idle gap.
                    tick_ok = tick;
                    state_d = tick ? SCAN : IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign scan_en   = (state_q == SCAN);
    assign scan_addr = addr_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign sp_out    = s2_valid & s2_fire;
    assign sp_addr   = s2_addr;

    assign ram_we    = (state_q == INIT) | s2_valid;
    assign ram_waddr = (state_q == INIT) ? addr_q : s2_addr;
    assign ram_wdata = ((state_q == INIT) || s2_fire) ? '0 : s2_vmem;

    vmem_ram #(
        .DEPTH (NEURON_NO),
        .WID   (VMEM_WID),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (addr_q),
        .rdata (ram_rdata)
    );

    // Same-cycle write/read of one address only happens for tiny arrays; bypass it.
    assign v_cur  = fwd_hit ? fwd_data : ram_rdata;
    assign v_leak = (LEAK_SHIFT == 0) ? '0 : (v_cur >> LEAK_SHIFT);
    assign v_next = VMEM_WID'(sat_add(64'(v_cur - v_leak), 64'(s1_ampl), VMEM_WID));
    assign fire   = (v_next >= THRESH);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_ampl  <= '0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
            s2_valid <= 1'b0;
            s2_fire  <= 1'b0;
            s2_addr  <= '0;
            s2_vmem  <= '0;
        end else begin
            s1_valid <= scan_en;
            s1_addr  <= addr_q;
            s1_ampl  <= ampl_in;
            fwd_hit  <= ram_we && (ram_waddr == addr_q);
            fwd_data <= ram_wdata;
            s2_valid <= s1_valid;
            s2_fire  <= fire;
            s2_addr  <= s1_addr;
            s2_vmem  <= v_next;
        end
    end

endmodule

// File: tb/tb_neuron_integrator.sv
// Directed bench for neuron_integrator: three 4-neuron instances cover plain
// accumulation, leak, and saturation; one shared monitor view selects between them.
module tb_neuron_integrator;

    logic        clk;
    logic        reset;
    logic        tick;
    logic [19:0] ampl;
    logic [1:0]  sel;
    int          compared;
    int          mismatched;

    logic       tick_a, tick_b, tick_c;
    logic       en_a, en_b, en_c, sp_a, sp_b, sp_c;
    logic [1:0] addr_a, addr_b, addr_c, spaddr_a, spaddr_b, spaddr_c;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic       ovr_a, ovr_b, ovr_c;

    logic       m_en, m_sp, m_busy, m_done, m_ovr;
    logic [1:0] m_addr, m_spaddr;

    assign tick_a = tick & (sel == 2'd0);
    assign tick_b = tick & (sel == 2'd1);
    assign tick_c = tick & (sel == 2'd2);

    neuron_integrator #(.NEURON_NO(4), .AMPL_WID(20), .VMEM_WID(24), .LEAK_SHIFT(0),
                        .THRESH(24'h001000)) dut_a (
        .clk(clk), .reset(reset), .tick(tick_a), .ampl_in(ampl),
        .scan_en(en_a), .scan_addr(addr_a), .sp_out(sp_a), .sp_addr(spaddr_a),
        .busy(busy_a), .done(done_a), .overrun(ovr_a));

    neuron_integrator #(.NEURON_NO(4), .AMPL_WID(20), .VMEM_WID(24), .LEAK_SHIFT(4),
                        .THRESH(24'h010000)) dut_b (
        .clk(clk), .reset(reset), .tick(tick_b), .ampl_in(ampl),
        .scan_en(en_b), .scan_addr(addr_b), .sp_out(sp_b), .sp_addr(spaddr_b),
        .busy(busy_b), .done(done_b), .overrun(ovr_b));

    neuron_integrator #(.NEURON_NO(4), .AMPL_WID(20), .VMEM_WID(20), .LEAK_SHIFT(4),
                        .THRESH(20'hFFFFF)) dut_c (
        .clk(clk), .reset(reset), .tick(tick_c), .ampl_in(ampl),
        .scan_en(en_c), .scan_addr(addr_c), .sp_out(sp_c), .sp_addr(spaddr_c),
        .busy(busy_c), .done(done_c), .overrun(ovr_c));

    always_comb begin
        m_en = en_a; m_addr = addr_a; m_sp = sp_a; m_spaddr = spaddr_a;
        m_busy = busy_a; m_done = done_a; m_ovr = ovr_a;
        case (sel)
            2'd1: begin
                m_en = en_b; m_addr = addr_b; m_sp = sp_b; m_spaddr = spaddr_b;
                m_busy = busy_b; m_done = done_b; m_ovr = ovr_b;
            end
            2'd2: begin
                m_en = en_c; m_addr = addr_c; m_sp = sp_c; m_spaddr = spaddr_c;
                m_busy = busy_c; m_done = done_c; m_ovr = ovr_c;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sweep of the selected instance. Starts from IDLE (started=0) or from the
    // first SCAN cycle of a chained sweep (started=1); holds tick for 'hold' SCAN cycles.
    task automatic do_sweep(input logic [19:0] amp, input logic [3:0] exp_mask, input int hold,
                            input bit chain, input bit started, input string nm);
        logic [3:0] mask;
        int         scans, terr, oerr, done_k;
        bit         got_done;
        logic       hist_en [12];
        logic [1:0] hist_addr [12];
        mask = '0; scans = 0; terr = 0; oerr = 0; done_k = -1; got_done = 1'b0;
        ampl = amp;
        if (!started) begin
            tick = 1'b1;
            @(negedge clk);
        end
        for (int k = 0; k < 12 && !got_done; k++) begin
            tick = (k < hold);
            hist_en[k]   = m_en;
            hist_addr[k] = m_addr;
            if (m_en) begin
                if (m_addr !== 2'(scans)) oerr++;
                scans++;
            end
            if (m_sp) begin
                mask[m_spaddr] = 1'b1;
                if (k < 2) terr++;
                else if (!hist_en[k-2] || hist_addr[k-2] !== m_spaddr) terr++;
            end
            if (m_done) begin
                got_done = 1'b1;
                done_k   = k;
                if (chain) tick = 1'b1;
            end
            @(negedge clk);
        end
        tick = 1'b0;
        compared++;
        if (!got_done || done_k != 5) begin
            mismatched++;
            $display("FAIL %s done_cycle: got %0d, expected 5", nm, done_k);
        end
        compared++;
        if (scans != 4 || oerr != 0) begin
            mismatched++;
            $display("FAIL %s scan_count: got %0d issues (%0d out of order), expected 4 in order",
                     nm, scans, oerr);
        end
        compared++;
        if (mask !== exp_mask) begin
            mismatched++;
            $display("FAIL %s spike_mask: got %b, expected %b", nm, mask, exp_mask);
        end
        compared++;
        if (terr != 0) begin
            mismatched++;
            $display("FAIL %s spike_timing: %0d spikes not 2 cycles after their scan_addr, expected 0",
                     nm, terr);
        end
        compared++;
        if (chain) begin
            if (m_en !== 1'b1 || m_addr !== 2'd0 || m_done !== 1'b0) begin
                mismatched++;
                $display("FAIL %s chained_start: scan_en=%b scan_addr=%0d done=%b, expected 1/0/0",
                         nm, m_en, m_addr, m_done);
            end
        end else begin
            if (m_en !== 1'b0 || m_done !== 1'b0 || m_busy !== 1'b0) begin
                mismatched++;
                $display("FAIL %s back_to_idle: scan_en=%b done=%b busy=%b, expected 0/0/0",
                         nm, m_en, m_done, m_busy);
            end
        end
    endtask

    task automatic test_reset();
        int busy_cnt, bad;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (m_en !== 1'b0 || m_addr !== 2'd0 || m_sp !== 1'b0 || m_spaddr !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: scan_en=%b scan_addr=%0d sp_out=%b sp_addr=%0d, expected all 0",
                     m_en, m_addr, m_sp, m_spaddr);
        end
        compared++;
        if (m_done !== 1'b0 || m_ovr !== 1'b0 || m_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_flags: done=%b overrun=%b busy=%b, expected 0/0/1",
                     m_done, m_ovr, m_busy);
        end
        reset = 1'b0;
        busy_cnt = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_busy === 1'b1) busy_cnt++;
            if (m_en !== 1'b0 || m_sp !== 1'b0 || m_done !== 1'b0) bad++;
            @(negedge clk);
        end
        compared++;
        if (busy_cnt != 4) begin
            mismatched++;
            $display("FAIL init_length: busy for %0d cycles, expected 4", busy_cnt);
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL init_quiet: %0d cycles with scan_en/sp_out/done high, expected 0", bad);
        end
    endtask

    task automatic test_accumulate();
        do_sweep(20'h00400, 4'b0000, 0, 1'b0, 1'b0, "acc_sweep1");
        do_sweep(20'h00400, 4'b0000, 0, 1'b0, 1'b0, "acc_sweep2");
        do_sweep(20'h00400, 4'b0000, 0, 1'b0, 1'b0, "acc_sweep3");
        do_sweep(20'h00400, 4'b1111, 0, 1'b0, 1'b0, "acc_sweep4");
        do_sweep(20'h00400, 4'b0000, 0, 1'b0, 1'b0, "acc_after_fire");
    endtask

    task automatic test_overrun();
        compared++;
        if (m_ovr !== 1'b0) begin
            mismatched++;
            $display("FAIL overrun_clear: got %b, expected 0", m_ovr);
        end
        do_sweep(20'h00400, 4'b0000, 3, 1'b0, 1'b0, "overrun_sweep");
        compared++;
        if (m_ovr !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_set: got %b, expected 1", m_ovr);
        end
    endtask

    task automatic test_back_to_back();
        do_sweep(20'h00400, 4'b0000, 0, 1'b1, 1'b0, "b2b_first");
        do_sweep(20'h00400, 4'b1111, 0, 1'b0, 1'b1, "b2b_second");
        compared++;
        if (m_ovr !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_sticky: got %b, expected 1", m_ovr);
        end
    endtask

    task automatic test_leak();
        do_sweep(20'h00800, 4'b0000, 0, 1'b0, 1'b0, "leak_load");
        do_sweep(20'h00000, 4'b0000, 0, 1'b0, 1'b0, "leak_decay");
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (dut_b.u_ram.mem[i] !== 24'h000780) begin
                mismatched++;
                $display("FAIL leak_vmem[%0d]: got %h, expected 000780", i, dut_b.u_ram.mem[i]);
            end
        end
        // 0x780 - 0x78 + 0xF8F8 lands exactly on the 0x10000 threshold.
        do_sweep(20'h0F8F8, 4'b1111, 0, 1'b0, 1'b0, "leak_thresh_edge");
    endtask

    task automatic test_saturate();
        do_sweep(20'h00010, 4'b0000, 0, 1'b0, 1'b0, "sat_preload");
        do_sweep(20'hFFFFF, 4'b1111, 0, 1'b0, 1'b0, "sat_clamp");
        do_sweep(20'hFFFFE, 4'b0000, 0, 1'b0, 1'b0, "sat_below_max");
    endtask

    task automatic test_reset_mid_scan();
        int en_cnt;
        do_sweep(20'h00800, 4'b0000, 0, 1'b0, 1'b0, "mid_preload");
        ampl = 20'h00800;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (m_en !== 1'b1 || m_addr !== 2'd2 || m_sp !== 1'b1 || m_spaddr !== 2'd0) begin
            mismatched++;
            $display("FAIL mid_in_flight: scan_en=%b scan_addr=%0d sp_out=%b sp_addr=%0d, expected 1/2/1/0",
                     m_en, m_addr, m_sp, m_spaddr);
        end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (m_sp !== 1'b0 || m_en !== 1'b0 || m_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_abort: sp_out=%b scan_en=%b busy=%b, expected 0/0/1",
                     m_sp, m_en, m_busy);
        end
        reset = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_en !== 1'b0 || m_sp !== 1'b0) en_cnt++;
            @(negedge clk);
        end
        compared++;
        if (en_cnt != 0 || m_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reinit: %0d active cycles, busy=%b, expected 0 and 0", en_cnt, m_busy);
        end
        // Stale 0x800 entries would push 0xC00 over the threshold.
        do_sweep(20'h00C00, 4'b0000, 0, 1'b0, 1'b0, "mid_vmem_cleared");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        sel   = 2'd0;
        tick  = 1'b0;
        ampl  = '0;
        reset = 1'b1;
        test_reset();
        test_accumulate();
        test_overrun();
        test_back_to_back();
        sel = 2'd1;
        test_leak();
        sel = 2'd2;
        test_saturate();
        sel = 2'd0;
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
